// File: rtl/seq_alu_calc.sv
// rtl/seq_alu_calc.sv - multi-cycle unsigned add/sub/mul/div calculator with valid/ready handshakes
module seq_alu_calc #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   re,
    output logic                 dz
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [1:0]           op_r;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [CW-1:0]        idx;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     rem_nxt;
    logic [WIDTH-1:0]     quo_nxt;

    // Add/sub use the live operands so the result is registered on the accept edge.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        idx     = CW'(WIDTH - 1) - count;
        addend  = b_r[count] ? ({{WIDTH{1'b0}}, a_r} << count) : '0;
        acc_nxt = acc + addend;
        shifted = {rem, a_r[idx]};
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        rem_nxt = shifted[WIDTH-1:0];
        // Restoring step; with b==0 every trial succeeds, giving all-ones quotient and rem==a.
        if (shifted >= {1'b0, b_r}) begin
            rem_nxt = WIDTH'(shifted - {1'b0, b_r});
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            re        <= '0;
            dz        <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= OP_ADD;
            count     <= '0;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op;
                        count    <= '0;
                        acc      <= '0;
                        rem      <= '0;
                        quo      <= '0;
                        in_ready <= 1'b0;
                        if (op == OP_ADD || op == OP_SUB) begin
                            re        <= {{(WIDTH-1){1'b0}}, (op == OP_ADD) ? sum : diff};
                            dz        <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (op_r == OP_MUL) begin
                        acc <= acc_nxt;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        re        <= (op_r == OP_MUL) ? acc_nxt : {rem_nxt, quo_nxt};
                        dz        <= (op_r != OP_MUL) && (b_r == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
